sampn_iterator: RTL

- Multi-lane sample iterator. It produces the R14 sample stream consumed by the jitter/hash stage: triangle, color, SAMPS sample positions and per-lane valid bits.
- Accepts one bounding-boxed triangle at R13 through a ready/valid handshake.
- Walks the box in raster order at the current subsample pitch, emitting SAMPS horizontally adjacent samples per cycle.
- Holds off upstream via halt_RnnnnL until the walk completes.

---
 rtl/sampn_iter_pkg.sv | 22 ++
 rtl/sampn_lane_gen.sv | 34 +++
 rtl/sampn_iterator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sampn_iter_pkg.sv
// Shared types and helpers for the multi-lane sample iterator.
package sampn_iter_pkg;

    // Widest lane count the iterator is built for.
    localparam int unsigned LANE_MAX = 8;

    typedef enum logic {
        WAIT,
        TEST
    } state_e;

    // One-hot pitch to shift amount: [3]=1.0 -> 0, [2]=0.5 -> 1, [1]=0.25 -> 2, [0]=0.125 -> 3.
    function automatic logic [1:0] pitch_shift(input logic [3:0] sub);
        logic [1:0] s;
        s = 2'd0;
        if (sub[2]) s = 2'd1;
        if (sub[1]) s = 2'd2;
        if (sub[0]) s = 2'd3;
        return s;
    endfunction

endpackage

// File: rtl/sampn_lane_gen.sv
// Combinational lane generator: SAMPS horizontally adjacent positions from the
// cursor, each flagged valid when it still lies inside the box (signed compare
// at SIGFIG+1 bits so nothing wraps).
module sampn_lane_gen #(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned SAMPS  = 4
) (
    input  logic [SIGFIG-1:0]            i_cur_x,
    input  logic [SIGFIG-1:0]            i_cur_y,
    input  logic [SIGFIG-1:0]            i_step,
    input  logic [SIGFIG-1:0]            i_ur_x,
    output logic [SAMPS-1:0][SIGFIG-1:0] o_lane_x,
    output logic [SAMPS-1:0][SIGFIG-1:0] o_lane_y,
    output logic [SAMPS-1:0]             o_lane_valid
);

    // Walk an extended accumulator across the lanes.
    always_comb begin
        logic signed [SIGFIG:0] w_acc;
        logic signed [SIGFIG:0] w_ur_ext;
        w_acc    = {i_cur_x[SIGFIG-1], i_cur_x};
        w_ur_ext = {i_ur_x[SIGFIG-1], i_ur_x};
        o_lane_x     = '0;
        o_lane_y     = '0;
        o_lane_valid = '0;
        for (int k = 0; k < int'(SAMPS); k++) begin
            o_lane_x[k]     = w_acc[SIGFIG-1:0];
            o_lane_y[k]     = i_cur_y;
            o_lane_valid[k] = (w_acc <= w_ur_ext);
            w_acc           = w_acc + $signed({1'b0, i_step});
        end
    end

endmodule

// File: rtl/sampn_iterator.sv
// Multi-lane sample iterator: accepts a bounding-boxed triangle, walks the box in
// raster order at the subsample pitch and emits SAMPS samples per cycle.
// Optional valid-sample counter enabled by defining SAMPN_ITER_STATS_EN.
module sampn_iterator
    import sampn_iter_pkg::*;
#(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3,
    parameter int unsigned SAMPS  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
    input  logic                                     validTri_R13H,
    input  logic [3:0]                               subSample_RnnnnU,
    output logic                                     halt_RnnnnL,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0]        sample_R14S,
    output logic [SAMPS-1:0]                         validSamp_R14H,
    output logic [31:0]                              sampCount_RnnnnU
);

    localparam int SampShift = $clog2(SAMPS);

    state_e                                 r_state, w_state_nx;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
    logic [COLORS-1:0][SIGFIG-1:0]          r_color;
    logic [SIGFIG-1:0]                      r_ll_x, r_ur_x, r_ur_y, r_step;
    logic [SIGFIG-1:0]                      r_cur_x, r_cur_y, w_cur_x_nx, w_cur_y_nx;
    logic [SIGFIG-1:0]                      w_step_in;
    logic                                   w_accept;
    logic signed [SIGFIG:0]                 w_adv_x, w_adv_y;
    logic                                   w_x_fits, w_y_fits;
    logic [SAMPS-1:0][SIGFIG-1:0]           w_lane_x, w_lane_y;
    logic [SAMPS-1:0]                       w_lane_valid;

    assign w_accept    = (r_state == WAIT) && validTri_R13H;
    assign halt_RnnnnL = (r_state == WAIT);
    assign w_step_in   = SIGFIG'(1) << (int'(RADIX) - int'(pitch_shift(subSample_RnnnnU)));

    // Next cursor candidates, extended one bit so overflow is visible.
    assign w_adv_x  = $signed({r_cur_x[SIGFIG-1], r_cur_x}) + $signed({1'b0, r_step} << SampShift);
    assign w_adv_y  = $signed({r_cur_y[SIGFIG-1], r_cur_y}) + $signed({1'b0, r_step});
    assign w_x_fits = (w_adv_x <= $signed({r_ur_x[SIGFIG-1], r_ur_x}));
    assign w_y_fits = (w_adv_y <= $signed({r_ur_y[SIGFIG-1], r_ur_y}));

    sampn_lane_gen #(
        .SIGFIG (SIGFIG),
        .SAMPS  (SAMPS)
    ) u_lane_gen (
        .i_cur_x      (r_cur_x),
        .i_cur_y      (r_cur_y),
        .i_step       (r_step),
        .i_ur_x       (r_ur_x),
        .o_lane_x     (w_lane_x),
        .o_lane_y     (w_lane_y),
        .o_lane_valid (w_lane_valid)
    );

    // Next state and cursor: raster walk, row wrap, finish.
    always_comb begin
        w_state_nx = r_state;
        w_cur_x_nx = r_cur_x;
        w_cur_y_nx = r_cur_y;
        case (r_state)
            WAIT: begin
                if (validTri_R13H) begin
                    w_state_nx = TEST;
                    w_cur_x_nx = box_R13S[0][0];
                    w_cur_y_nx = box_R13S[0][1];
                end
            end
            TEST: begin
                if (w_x_fits) begin
                    w_cur_x_nx = w_adv_x[SIGFIG-1:0];
                end else if (w_y_fits) begin
                    w_cur_x_nx = r_ll_x;
                    w_cur_y_nx = w_adv_y[SIGFIG-1:0];
                end else begin
                    w_state_nx = WAIT;
                end
            end
            default: w_state_nx = WAIT;
        endcase
    end

    // State and cursor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT;
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cur_x <= w_cur_x_nx;
            r_cur_y <= w_cur_y_nx;
        end
    end

    // Triangle, box and pitch are captured at accept and held for the walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tri   <= '0;
            r_color <= '0;
            r_ll_x  <= '0;
            r_ur_x  <= '0;
            r_ur_y  <= '0;
            r_step  <= '0;
        end else if (w_accept) begin
            r_tri   <= tri_R13S;
            r_color <= color_R13U;
            r_ll_x  <= box_R13S[0][0];
            r_ur_x  <= box_R13S[1][0];
            r_ur_y  <= box_R13S[1][1];
            r_step  <= w_step_in;
        end
    end

    // R14 outputs: update while walking, hold payload with lanes invalid otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_R14S       <= '0;
            color_R14U     <= '0;
            sample_R14S    <= '0;
            validSamp_R14H <= '0;
        end else if (r_state == TEST) begin
            tri_R14S       <= r_tri;
            color_R14U     <= r_color;
            sample_R14S[0] <= w_lane_x;
            sample_R14S[1] <= w_lane_y;
            validSamp_R14H <= w_lane_valid;
        end else begin
            validSamp_R14H <= '0;
        end
    end

    // Pitch must be one-hot at accept; cursor sums must never wrap.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            assert ($onehot(subSample_RnnnnU)) else $error("subSample not one-hot");
        end
        if (!rst && r_state == TEST) begin
            assert (w_adv_x[SIGFIG] == w_adv_x[SIGFIG-1]) else $error("cursor x overflow");
            assert (w_adv_y[SIGFIG] == w_adv_y[SIGFIG-1]) else $error("cursor y overflow");
        end
    end

`ifdef SAMPN_ITER_STATS_EN
    localparam int unsigned PopW = $clog2(LANE_MAX + 1);

    logic [PopW-1:0] w_pop;
    logic [32:0]     w_count_sum;
    logic [31:0]     r_samp_count;

    // Popcount of the lanes presented this cycle.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < int'(SAMPS); k++) begin
            w_pop = w_pop + PopW'(validSamp_R14H[k]);
        end
    end

    assign w_count_sum = {1'b0, r_samp_count} + 33'(w_pop);

    // Saturating valid-sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_count <= '0;
        end else if (w_count_sum[32]) begin
            r_samp_count <= '1;
        end else begin
            r_samp_count <= w_count_sum[31:0];
        end
    end

    assign sampCount_RnnnnU = r_samp_count;
`else
    assign sampCount_RnnnnU = '0;
`endif

endmodule
